// File: rtl/moment_div_sched.sv
// moment_div_sched: turns frame moments into a clamped centroid by sequencing two
// divisions (m10/m00, m01/m00) through a shared divider, with a qv watchdog.
module moment_div_sched #(
   parameter int IMG_W   = 720,
   parameter int IMG_H   = 576,
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        eof,
   input  logic [18:0] m00,
   input  logic [18:0] m10,
   input  logic [18:0] m01,
   output logic        div_start,
   output logic [27:0] div_dividend,
   output logic [19:0] div_divisor,
   input  logic [27:0] div_quotient,
   input  logic        div_qv,
   output logic [9:0]  x,
   output logic [9:0]  y,
   output logic        valid,
   output logic        busy,
   output logic        no_object,
   output logic        overrun,
   output logic        timeout_err
);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, START_X, WAIT_X, START_Y, WAIT_Y, DONE} state_t;

   state_t state_q, state_d;
   logic [18:0] m00_q, m00_d, m10_q, m10_d, m01_q, m01_d;
   logic [9:0]  tx_q, tx_d, x_q, x_d, y_q, y_d;
   logic        valid_q, valid_d, no_object_q, no_object_d;
   logic        overrun_q, overrun_d, timeout_err_q, timeout_err_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [9:0]  qx, qy;
   logic        accept, waiting, expired, fin;

   assign qx      = (div_quotient >= 28'(IMG_W)) ? 10'(IMG_W - 1) : div_quotient[9:0];
   assign qy      = (div_quotient >= 28'(IMG_H)) ? 10'(IMG_H - 1) : div_quotient[9:0];
   assign accept  = (state_q == IDLE) && eof;
   assign waiting = (state_q == WAIT_X) || (state_q == WAIT_Y);
   // qv on the final counted cycle still wins over the watchdog
   assign expired = waiting && !div_qv && (cnt_q == CW'(TIMEOUT - 1));
   assign fin     = (state_q == WAIT_Y) && div_qv;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         m00_q         <= '0;
         m10_q         <= '0;
         m01_q         <= '0;
         tx_q          <= '0;
         x_q           <= '0;
         y_q           <= '0;
         valid_q       <= 1'b0;
         no_object_q   <= 1'b0;
         overrun_q     <= 1'b0;
         timeout_err_q <= 1'b0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         m00_q         <= m00_d;
         m10_q         <= m10_d;
         m01_q         <= m01_d;
         tx_q          <= tx_d;
         x_q           <= x_d;
         y_q           <= y_d;
         valid_q       <= valid_d;
         no_object_q   <= no_object_d;
         overrun_q     <= overrun_d;
         timeout_err_q <= timeout_err_d;
         cnt_q         <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (eof) state_d = (m00 != '0) ? START_X : DONE;
         START_X: state_d = WAIT_X;
         WAIT_X:  state_d = div_qv ? START_Y : expired ? IDLE : WAIT_X;
         START_Y: state_d = WAIT_Y;
         WAIT_Y:  state_d = div_qv ? DONE : expired ? IDLE : WAIT_Y;
         default: state_d = IDLE;
      endcase
   end

   // x and y are written on the same edge that raises valid, so they are never split
   always_comb begin
      m00_d         = accept ? m00 : m00_q;
      m10_d         = accept ? m10 : m10_q;
      m01_d         = accept ? m01 : m01_q;
      tx_d          = ((state_q == WAIT_X) && div_qv) ? qx : tx_q;
      x_d           = fin ? tx_q : x_q;
      y_d           = fin ? qy : y_q;
      valid_d       = fin;
      no_object_d   = (accept && (m00 == '0)) ? 1'b1 : fin ? 1'b0 : no_object_q;
      overrun_d     = overrun_q | (eof && (state_q != IDLE));
      timeout_err_d = timeout_err_q | expired;
      cnt_d         = ((state_q == START_X) || (state_q == START_Y)) ? CW'(1) :
                      waiting ? cnt_q + CW'(1) : '0;
   end

   always_comb begin
      div_start    = (state_q == START_X) || (state_q == START_Y);
      busy         = state_q != IDLE;
      div_dividend = {9'b0, ((state_q == START_Y) || (state_q == WAIT_Y)) ? m01_q : m10_q};
      div_divisor  = {1'b0, m00_q};
      x            = x_q;
      y            = y_q;
      valid        = valid_q;
      no_object    = no_object_q;
      overrun      = overrun_q;
      timeout_err  = timeout_err_q;
   end
endmodule

// File: tb/tb_moment_div_sched.sv
// tb_moment_div_sched: directed bench; the divider is played by hand with known quotients.
`timescale 1ns/1ps
module tb_moment_div_sched;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        eof = 1'b0;
   logic [18:0] m00 = '0, m10 = '0, m01 = '0;
   logic        div_start, valid, busy, no_object, overrun, timeout_err;
   logic [27:0] div_dividend;
   logic [19:0] div_divisor;
   logic [27:0] div_quotient = '0;
   logic        div_qv = 1'b0;
   logic [9:0]  x, y;
   int n_assert = 0;
   int n_fail   = 0;

   moment_div_sched dut (
      .clk(clk), .rst(rst), .eof(eof), .m00(m00), .m10(m10), .m01(m01),
      .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_quotient(div_quotient), .div_qv(div_qv), .x(x), .y(y), .valid(valid),
      .busy(busy), .no_object(no_object), .overrun(overrun), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic frame(input logic [18:0] a, input logic [18:0] b, input logic [18:0] c);
      eof = 1'b1; m00 = a; m10 = b; m01 = c;
      step();
      eof = 1'b0;
   endtask

   initial begin
      // reset state
      #2;
      chk("rst_x", x, 0);            chk("rst_y", y, 0);
      chk("rst_valid", valid, 0);    chk("rst_busy", busy, 0);
      chk("rst_start", div_start, 0);chk("rst_noobj", no_object, 0);
      chk("rst_ovr", overrun, 0);    chk("rst_tmo", timeout_err, 0);
      chk("rst_dvd", div_dividend, 0); chk("rst_dvs", div_divisor, 0);
      step(); step();
      rst = 1'b1;
      step();
      chk("rel_start", div_start, 0); chk("rel_busy", busy, 0);

      // nominal frame, divider latency 30
      frame(19'd100, 19'd36000, 19'd28800);
      chk("a_start1", div_start, 1); chk("a_dvd1", div_dividend, 36000);
      chk("a_dvs1", div_divisor, 100); chk("a_busy", busy, 1);
      repeat (29) step();
      chk("a_nostart", div_start, 0); chk("a_dvd_hold", div_dividend, 36000);
      div_qv = 1'b1; div_quotient = 28'd360;
      step();
      div_qv = 1'b0; div_quotient = '0;
      chk("a_start2", div_start, 1); chk("a_dvd2", div_dividend, 28800);
      chk("a_dvs2", div_divisor, 100); chk("a_nopartial", x, 0);
      repeat (29) step();
      chk("a_dvd2_hold", div_dividend, 28800); chk("a_novalid", valid, 0);
      div_qv = 1'b1; div_quotient = 28'd288;
      step();
      div_qv = 1'b0;
      chk("a_valid", valid, 1); chk("a_x", x, 360); chk("a_y", y, 288);
      chk("a_noobj", no_object, 0);
      step();
      chk("a_valid_pulse", valid, 0); chk("a_idle", busy, 0);

      // empty mask
      frame(19'd0, 19'd5, 19'd7);
      chk("b_start", div_start, 0); chk("b_noobj", no_object, 1); chk("b_valid", valid, 0);
      step();
      chk("b_start2", div_start, 0); chk("b_valid2", valid, 0); chk("b_idle", busy, 0);
      chk("b_x", x, 360); chk("b_y", y, 288); chk("b_noobj2", no_object, 1);

      // second eof five cycles after the first
      frame(19'd50, 19'd10000, 19'd5000);
      chk("c_start", div_start, 1); chk("c_ovr0", overrun, 0);
      repeat (4) step();
      frame(19'd10, 19'd20, 19'd30);
      chk("c_ovr", overrun, 1); chk("c_dvs", div_divisor, 50); chk("c_dvd", div_dividend, 10000);
      div_qv = 1'b1; div_quotient = 28'd200;
      step();
      div_qv = 1'b0;
      chk("c_dvd2", div_dividend, 5000);
      step();
      div_qv = 1'b1; div_quotient = 28'd100;
      step();
      div_qv = 1'b0;
      chk("c_valid", valid, 1); chk("c_x", x, 200); chk("c_y", y, 100); chk("c_noobj", no_object, 0);
      step();

      // stray qv in IDLE, then clamping
      div_qv = 1'b1; div_quotient = 28'd5;
      step();
      div_qv = 1'b0;
      chk("d_stray_busy", busy, 0); chk("d_stray_valid", valid, 0); chk("d_stray_x", x, 200);
      frame(19'd1, 19'd1000, 19'd700);
      step();
      div_qv = 1'b1; div_quotient = 28'd1000;
      step();
      div_qv = 1'b0;
      step();
      div_qv = 1'b1; div_quotient = 28'd700;
      step();
      div_qv = 1'b0;
      chk("d_valid", valid, 1); chk("d_x", x, 719); chk("d_y", y, 575);
      step();

      // watchdog: divider silent
      frame(19'd4, 19'd40, 19'd40);
      chk("e_start", div_start, 1);
      repeat (63) step();
      chk("e_tmo_early", timeout_err, 0); chk("e_busy", busy, 1);
      step();
      chk("e_tmo", timeout_err, 1); chk("e_idle", busy, 0); chk("e_valid", valid, 0);
      chk("e_x", x, 719); chk("e_y", y, 575);
      frame(19'd2, 19'd20, 19'd10);
      chk("e_accept", div_start, 1); chk("e_dvd", div_dividend, 20);
      step();
      div_qv = 1'b1; div_quotient = 28'd10;
      step();
      div_qv = 1'b0;
      step();
      div_qv = 1'b1; div_quotient = 28'd5;
      step();
      div_qv = 1'b0;
      chk("e_valid2", valid, 1); chk("e_x2", x, 10); chk("e_y2", y, 5);
      chk("e_tmo_sticky", timeout_err, 1); chk("e_ovr_sticky", overrun, 1);
      step();

      // reset while waiting for the second quotient
      frame(19'd3, 19'd300, 19'd30);
      step();
      div_qv = 1'b1; div_quotient = 28'd100;
      step();
      div_qv = 1'b0;
      step();
      chk("f_wait_y", div_dividend, 30);
      #2 rst = 1'b0;
      #1;
      chk("f_x", x, 0); chk("f_y", y, 0); chk("f_busy", busy, 0);
      chk("f_ovr", overrun, 0); chk("f_tmo", timeout_err, 0);
      chk("f_dvd", div_dividend, 0); chk("f_dvs", div_divisor, 0);
      step();
      rst = 1'b1;
      div_qv = 1'b1; div_quotient = 28'd10;
      step();
      div_qv = 1'b0;
      chk("f_late_valid", valid, 0); chk("f_late_busy", busy, 0);
      chk("f_late_start", div_start, 0); chk("f_late_y", y, 0);
      step();
      chk("f_late_valid2", valid, 0); chk("f_late_x", x, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/moment_div_sched.md
MOMENT_DIV_SCHED -- requirements
Module: moment_div_sched

Interface
REQ-001 Parameter IMG_W, default 720, image width in pixels; used for the x clamp.
REQ-002 Parameter IMG_H, default 576, image height in pixels; used for the y clamp.
REQ-003 Parameter TIMEOUT, default 64, maximum cycles to wait for divider qv before abort.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 eof  input  1  one-cycle end-of-frame pulse; moments valid in the same cycle.
REQ-007 m00  input  19  mask pixel count.
REQ-008 m10  input  19  sum of x over mask pixels.
REQ-009 m01  input  19  sum of y over mask pixels.
REQ-010 div_start  output  1  one-cycle start pulse to the shared 28/20 divider.
REQ-011 div_dividend  output  28  {9'b0, latched m10 or m01}.
REQ-012 div_divisor  output  20  {1'b0, latched m00}.
REQ-013 div_quotient  input  28  divider result.
REQ-014 div_qv  input  1  one-cycle quotient-valid pulse.
REQ-015 x  output  10  latched centroid x.
REQ-016 y  output  10  latched centroid y.
REQ-017 valid  output  1  one-cycle pulse when x and y are updated together.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 no_object  output  1  level; set when the last frame had m00 == 0.
REQ-020 overrun  output  1  sticky; set when eof arrives while busy.
REQ-021 timeout_err  output  1  sticky; set when the divider watchdog expires.

Function
REQ-022 States SHALL be IDLE, START_X, WAIT_X, START_Y, WAIT_Y, DONE.
REQ-023 IDLE with eof=1 SHALL latch m00/m10/m01 into internal registers; next state START_X if m00!=0, else DONE with no_object set.
REQ-024 START_X SHALL assert div_start for exactly one cycle with the dividend from the latched m10, then go to WAIT_X.
REQ-025 WAIT_X on div_qv SHALL capture div_quotient into a temporary x, then go to START_Y.
REQ-026 START_Y and WAIT_Y SHALL do the same with the latched m01 for temporary y; WAIT_Y on div_qv goes to DONE.
REQ-027 div_dividend and div_divisor SHALL hold stable from the div_start cycle until the matching div_qv.
REQ-028 Clamp: quotient >= IMG_W SHALL store IMG_W-1 for x; quotient >= IMG_H SHALL store IMG_H-1 for y; otherwise store quotient[9:0].
REQ-029 DONE, when reached via the division path, SHALL copy the temporaries to x and y, pulse valid, clear no_object, then return to IDLE.
REQ-030 DONE, when reached with m00==0, SHALL hold x and y, pulse no valid, then return to IDLE.
REQ-031 Latency: eof at cycle N gives div_start at N+1; valid at Q+1, where Q is the cycle of the second div_qv.
REQ-032 Watchdog: in WAIT_X or WAIT_Y, a counter reaching TIMEOUT without div_qv SHALL set timeout_err and go to IDLE with x, y and valid unchanged.
REQ-033 eof while busy=1 (including in DONE) SHALL be ignored, SHALL set overrun, and SHALL NOT alter the latched moments.
REQ-034 div_qv in any state other than WAIT_X or WAIT_Y SHALL be ignored.
REQ-035 x and y SHALL never be partially updated; both change only in the valid cycle.
REQ-036 overrun and timeout_err SHALL clear only on reset.

Reset
REQ-037 rst=0 SHALL immediately force the state to IDLE.
REQ-038 rst=0 SHALL immediately force x=0, y=0, valid=0, busy=0, div_start=0, no_object=0, overrun=0, timeout_err=0, and the watchdog counter to 0.
REQ-039 rst=0 SHALL immediately force the latched moments and the div_dividend/div_divisor outputs to 0.
REQ-040 Reset asserted mid-division SHALL abandon the operation; a later div_qv SHALL be ignored.
REQ-041 Release of reset SHALL take effect on the next clk edge, with no spurious div_start.

Verification
REQ-042 eof with m00=100, m10=36000, m01=28800; divider model latency 30 -> div_start at N+1 (dividend 36000, divisor 100), second div_start after the first qv (dividend 28800); valid with x=360, y=288.
REQ-043 eof with m00=0 -> no div_start, no_object=1, no valid, x and y keep their previous values.
REQ-044 Second eof 5 cycles after the first -> overrun=1; result reflects the first frame's moments only.
REQ-045 Divider never asserts qv, TIMEOUT=64 -> timeout_err=1 64 cycles after div_start; state IDLE; x and y unchanged; the next eof is accepted.
REQ-046 m00=1, m10=1000, m01=700 -> x=719 and y=575 (clamped).
REQ-047 rst=0 asserted while in WAIT_Y, followed by a late div_qv -> all outputs 0, no valid.
